// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch core.
// Optional lap hold is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t tenths;
  } sw_time_t;

  // True when the time reads max_min:59.9, the last value before wrap.
  function automatic logic sw_time_at_max(input sw_time_t t, input int unsigned max_min);
    return (t.min_tens == bcd_t'(max_min / 10)) &&
           (t.min_ones == bcd_t'(max_min % 10)) &&
           (t.sec_tens == bcd_t'(SEC_TENS_MAX)) &&
           (t.sec_ones == bcd_t'(DIGIT_MAX)) &&
           (t.tenths   == bcd_t'(DIGIT_MAX));
  endfunction

  // One-tenth increment with ripple carry; the max wrap is handled by the caller.
  function automatic sw_time_t sw_time_inc(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.tenths != bcd_t'(DIGIT_MAX)) begin
      r.tenths = t.tenths + bcd_t'(1);
    end else begin
      r.tenths = '0;
      if (t.sec_ones != bcd_t'(DIGIT_MAX)) begin
        r.sec_ones = t.sec_ones + bcd_t'(1);
      end else begin
        r.sec_ones = '0;
        if (t.sec_tens != bcd_t'(SEC_TENS_MAX)) begin
          r.sec_tens = t.sec_tens + bcd_t'(1);
        end else begin
          r.sec_tens = '0;
          if (t.min_ones != bcd_t'(DIGIT_MAX)) begin
            r.min_ones = t.min_ones + bcd_t'(1);
          end else begin
            r.min_ones = '0;
            r.min_tens = (t.min_tens == bcd_t'(DIGIT_MAX)) ? '0 : t.min_tens + bcd_t'(1);
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button pulses in, BCD digits and status pulses out.
// The lap signal exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic start_stop;
  logic clear;
`ifdef STOPWATCH_LAP_EN
  logic lap;
`endif
  bcd_t tenths;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic running;
  logic tick;
  logic overflow;

`ifdef STOPWATCH_LAP_EN
  modport master (
    output start_stop, clear, lap,
    input  tenths, sec_ones, sec_tens, min_ones, min_tens, running, tick, overflow
  );
  modport slave (
    input  start_stop, clear, lap,
    output tenths, sec_ones, sec_tens, min_ones, min_tens, running, tick, overflow
  );
`else
  modport master (
    output start_stop, clear,
    input  tenths, sec_ones, sec_tens, min_ones, min_tens, running, tick, overflow
  );
  modport slave (
    input  start_stop, clear,
    output tenths, sec_ones, sec_tens, min_ones, min_tens, running, tick, overflow
  );
`endif

endinterface

// File: rtl/edge_tick_sync.sv
// Synchronises the slow divided clock into clk and emits a one-cycle tick per rising edge.
module edge_tick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_out;
      tick   <= sync_out & ~prev_q;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// BCD MM:SS.t stopwatch counting synchronised slow_clk ticks under an IDLE/RUN/PAUSE FSM.
// Define STOPWATCH_LAP_EN to add the lap input and display hold register.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_clk,
  stopwatch_if.slave  sw
);

  logic      tick_q;
  sw_state_t state_q;
  sw_state_t state_d;
  logic      count_en_c;
  logic      wrap_c;
  sw_time_t  cnt_q;
  sw_time_t  cnt_d;
  sw_time_t  disp;
  logic      running_q;
  logic      overflow_q;

  edge_tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (slow_clk),
    .tick     (tick_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; clear dominates, and a tick only counts while already in RUN.
  always_comb begin
    state_d    = state_q;
    count_en_c = 1'b0;
    if (sw.clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (sw.start_stop) state_d = ST_RUN;
        ST_RUN: begin
          count_en_c = tick_q;
          if (sw.start_stop) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (sw.start_stop) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wrap_c = count_en_c && sw_time_at_max(cnt_q, MAX_MIN);
    if (sw.clear || wrap_c) cnt_d = '0;
    else if (count_en_c)    cnt_d = sw_time_inc(cnt_q);
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      running_q  <= (state_d == ST_RUN);
      overflow_q <= wrap_c;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic     hold_q;
  logic     hold_d;
  sw_time_t lap_q;
  sw_time_t lap_d;
  sw_time_t disp_d;
  sw_time_t disp_q;

  // Lap toggles hold in RUN; latching cnt_d folds in a coincident tick.
  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (sw.clear) begin
      hold_d = 1'b0;
    end else if (sw.lap && (state_q == ST_RUN)) begin
      hold_d = ~hold_q;
      if (!hold_q) lap_d = cnt_d;
    end
    disp_d = hold_d ? lap_d : cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
      disp_q <= '0;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
      disp_q <= disp_d;
    end
  end

  assign disp = disp_q;
`else
  assign disp = cnt_q;
`endif

  assign sw.tenths   = disp.tenths;
  assign sw.sec_ones = disp.sec_ones;
  assign sw.sec_tens = disp.sec_tens;
  assign sw.min_ones = disp.min_ones;
  assign sw.min_tens = disp.min_tens;
  assign sw.running  = running_q;
  assign sw.tick     = tick_q;
  assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core; lap sequence runs when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

  localparam int unsigned MAXM   = 1;
  localparam int          WRAP_T = (MAXM + 1) * 600;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic slow_clk = 1'b0;

  always #5 clk = ~clk;

  stopwatch_if swi ();

  stopwatch_core #(
    .SYNC_STAGES (2),
    .MAX_MIN     (MAXM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .sw       (swi)
  );

  typedef enum {OP_SS, OP_CLR, OP_CLR_SS, OP_TICKS} op_e;
  typedef struct {
    op_e op;
    int  n;
    int  exp_t;
    bit  exp_run;
  } vec_t;

  typedef struct {
    int t;
    bit ovf;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int tick_count = 0;
  int model_t    = 0;
  int lap_t      = 0;
  bit model_run  = 1'b0;
  bit model_hold = 1'b0;
  bit pend       = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int to_digits(input int t);
    int m, s, d;
    m = t / 600;
    s = (t / 10) % 60;
    d = t % 10;
    return ((m / 10) << 16) | ((m % 10) << 12) | ((s / 10) << 8) | ((s % 10) << 4) | d;
  endfunction

  function automatic int dut_digits();
    return {12'd0, swi.min_tens, swi.min_ones, swi.sec_tens, swi.sec_ones, swi.tenths};
  endfunction

  function automatic int disp_t();
    return model_hold ? lap_t : model_t;
  endfunction

  // Digits settle the cycle after each tick; pop the expectation pushed for that slow_clk edge.
  always @(negedge clk) begin : monitor
    sb_item_t it;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_tick", 1, 0);
        end else begin
          it = sb.pop_front();
          check("sb_digits", dut_digits(), to_digits(it.t));
          check("sb_overflow", int'(swi.overflow), int'(it.ovf));
        end
      end
      pend = swi.tick;
      if (swi.tick) tick_count++;
    end
  end

  task automatic pulse(input bit ss, input bit clr, input bit lp);
    @(negedge clk);
    swi.start_stop = ss;
    swi.clear      = clr;
`ifdef STOPWATCH_LAP_EN
    swi.lap        = lp;
`endif
    @(negedge clk);
    swi.start_stop = 1'b0;
    swi.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    swi.lap        = 1'b0;
`endif
    if (clr) begin
      model_t    = 0;
      model_run  = 1'b0;
      model_hold = 1'b0;
    end else begin
      if (lp && model_run) begin
        if (!model_hold) lap_t = model_t;
        model_hold = !model_hold;
      end
      if (ss) model_run = !model_run;
    end
  endtask

  task automatic push_tick();
    sb_item_t it;
    it.ovf = 1'b0;
    if (model_run) begin
      model_t++;
      if (model_t == WRAP_T) begin
        model_t = 0;
        it.ovf  = 1'b1;
      end
    end
    it.t = disp_t();
    sb.push_back(it);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      push_tick();
      slow_clk = 1'b1;
      repeat (5) @(negedge clk);
      slow_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[13];
    int   tc0;
    bit   seen;

    tbl[0]  = '{OP_CLR,    0,  0, 1'b0};
    tbl[1]  = '{OP_SS,     0,  0, 1'b1};
    tbl[2]  = '{OP_TICKS, 10, 10, 1'b1};
    tbl[3]  = '{OP_CLR,    0,  0, 1'b0};
    tbl[4]  = '{OP_SS,     0,  0, 1'b1};
    tbl[5]  = '{OP_TICKS,  5,  5, 1'b1};
    tbl[6]  = '{OP_SS,     0,  5, 1'b0};
    tbl[7]  = '{OP_TICKS,  3,  5, 1'b0};
    tbl[8]  = '{OP_SS,     0,  5, 1'b1};
    tbl[9]  = '{OP_TICKS,  2,  7, 1'b1};
    tbl[10] = '{OP_TICKS, 25, 32, 1'b1};
    tbl[11] = '{OP_CLR_SS, 0,  0, 1'b0};
    tbl[12] = '{OP_TICKS,  2,  0, 1'b0};

    swi.start_stop = 1'b0;
    swi.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    swi.lap        = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_digits", dut_digits(), 0);
    check("rst_running", int'(swi.running), 0);
    check("rst_tick", int'(swi.tick), 0);
    check("rst_overflow", int'(swi.overflow), 0);

    for (int i = 0; i < 13; i++) begin
      tc0 = tick_count;
      case (tbl[i].op)
        OP_SS:     pulse(1'b1, 1'b0, 1'b0);
        OP_CLR:    pulse(1'b0, 1'b1, 1'b0);
        OP_CLR_SS: pulse(1'b1, 1'b1, 1'b0);
        default:   ticks(tbl[i].n);
      endcase
      check($sformatf("vec%0d_digits", i), dut_digits(), to_digits(tbl[i].exp_t));
      check($sformatf("vec%0d_running", i), int'(swi.running), int'(tbl[i].exp_run));
      if (tbl[i].op == OP_TICKS)
        check($sformatf("vec%0d_tick_count", i), tick_count - tc0, tbl[i].n);
    end

    // start_stop landing on the tick cycle: tick counts, then PAUSE
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(4);
    push_tick();
    slow_clk = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = swi.tick;
    end
    check("coinc_tick_seen", int'(seen), 1);
    swi.start_stop = 1'b1;
    model_run      = 1'b0;
    @(negedge clk);
    swi.start_stop = 1'b0;
    repeat (3) @(negedge clk);
    slow_clk = 1'b0;
    repeat (5) @(negedge clk);
    check("coinc_digits", dut_digits(), to_digits(5));
    check("coinc_running", int'(swi.running), 0);
    ticks(2);
    check("coinc_paused_digits", dut_digits(), to_digits(5));

    // asynchronous reset mid-RUN with a tick in flight through the synchroniser
    pulse(1'b1, 1'b0, 1'b0);
    ticks(3);
    check("prerst_digits", dut_digits(), to_digits(8));
    slow_clk = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("asyncrst_digits", dut_digits(), 0);
    check("asyncrst_running", int'(swi.running), 0);
    check("asyncrst_tick", int'(swi.tick), 0);
    sb.delete();
    model_t    = 0;
    model_run  = 1'b0;
    model_hold = 1'b0;
    slow_clk   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tc0 = tick_count;
    repeat (12) @(negedge clk);
    check("postrst_no_tick", tick_count - tc0, 0);
    check("postrst_digits", dut_digits(), 0);
    check("postrst_running", int'(swi.running), 0);

    // run to MAX_MIN:59.9 and wrap
    pulse(1'b1, 1'b0, 1'b0);
    ticks(WRAP_T - 1);
    check("premax_digits", dut_digits(), to_digits(WRAP_T - 1));
    ticks(1);
    check("wrap_digits", dut_digits(), 0);
    check("wrap_overflow_low", int'(swi.overflow), 0);
    check("wrap_running", int'(swi.running), 1);
    ticks(1);
    check("postwrap_digits", dut_digits(), to_digits(1));

`ifdef STOPWATCH_LAP_EN
    // lap hold freezes the display while the counter keeps running
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(20);
    check("lap_pre_digits", dut_digits(), to_digits(20));
    pulse(1'b0, 1'b0, 1'b1);
    ticks(5);
    check("lap_hold_digits", dut_digits(), to_digits(20));
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_release_digits", dut_digits(), to_digits(25));
    pulse(1'b0, 1'b0, 1'b1);
    ticks(3);
    check("lap_rehold_digits", dut_digits(), to_digits(25));
    pulse(1'b0, 1'b1, 1'b0);
    check("lap_clear_digits", dut_digits(), 0);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(1);
    check("lap_after_clear", dut_digits(), to_digits(1));
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    ticks(2);
    check("lap_ignored_in_pause", dut_digits(), to_digits(1));
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
